fetch_sequencer: RTL and testbench

Multi-cycle fetch controller that owns the program counter and sequences instruction-memory accesses. It issues one request at a time, buffers the returned word and hands it to decode over a valid/ready handshake. It applies PC-relative branch redirects (target = branch PC + offset) and flushes any fetch already in flight. It sits between instruction memory and the decode stage of the multi-cycle core.

---
 rtl/fetch_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, issues one instruction-memory request at a time,
// buffers the returned word for decode and applies PC-relative branch redirects.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] redirect_offset,
   output logic [31:0] pc_out,
   output logic        misalign_fault,
   output logic        timeout_fault
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_FAULT
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              flush_q, flush_d;
   logic              mfault_q, mfault_d;
   logic              tfault_q, tfault_d;

   logic [XLEN-1:0]   target_c;
   logic              misalign_c;
   logic              timeout_c;

   assign target_c   = redirect_pc + redirect_offset;
   assign misalign_c = redirect_en && (target_c[1:0] != 2'b00);
   assign timeout_c  = !imem_ready && (cnt_q == CNT_LAST);

   // Next-state logic; a misaligned redirect faults from any live state.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      cnt_d      = cnt_q;
      flush_d    = flush_q;
      mfault_d   = mfault_q;
      tfault_d   = tfault_q;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (misalign_c) begin
               state_d  = S_FAULT;
               mfault_d = 1'b1;
            end else if (redirect_en) begin
               pc_d = target_c;
            end
         end

         S_REQ: begin
            cnt_d   = '0;
            state_d = S_WAIT;
            if (misalign_c) begin
               state_d  = S_FAULT;
               mfault_d = 1'b1;
            end else if (redirect_en) begin
               pc_d    = target_c;
               flush_d = 1'b1;
            end
         end

         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout_c) begin
               state_d  = S_FAULT;
               tfault_d = 1'b1;
               if (misalign_c) mfault_d = 1'b1;
            end else if (misalign_c) begin
               state_d  = S_FAULT;
               mfault_d = 1'b1;
            end else if (imem_ready) begin
               // A response to a superseded fetch is dropped and the new target fetched.
               if (redirect_en || flush_q) begin
                  if (redirect_en) pc_d = target_c;
                  flush_d = 1'b0;
                  state_d = S_REQ;
               end else begin
                  instr_d    = imem_rdata;
                  instr_pc_d = pc_q;
                  pc_d       = pc_q + XLEN'(4);
                  state_d    = S_HOLD;
               end
            end else if (redirect_en) begin
               pc_d    = target_c;
               flush_d = 1'b1;
            end
         end

         S_HOLD: begin
            if (misalign_c) begin
               state_d  = S_FAULT;
               mfault_d = 1'b1;
            end else if (redirect_en) begin
               pc_d    = target_c;
               state_d = S_REQ;
            end else if (instr_ready) begin
               state_d = S_REQ;
            end
         end

         S_FAULT: begin
            state_d = S_FAULT;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         cnt_q      <= '0;
         flush_q    <= 1'b0;
         mfault_q   <= 1'b0;
         tfault_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         cnt_q      <= cnt_d;
         flush_q    <= flush_d;
         mfault_q   <= mfault_d;
         tfault_q   <= tfault_d;
      end
   end

   assign imem_req       = (state_q == S_REQ);
   assign imem_addr      = imem_req ? pc_q : '0;
   assign instr_valid    = (state_q == S_HOLD);
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign pc_out         = pc_q;
   assign misalign_fault = mfault_q;
   assign timeout_fault  = tfault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle table for the main flow plus
// hand-written reset, misalignment and timeout sequences.
module tb_fetch_sequencer;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic [31:0] redirect_offset;
   logic [31:0] pc_out;
   logic        misalign_fault;
   logic        timeout_fault;

   always #5 clk = ~clk;

   fetch_sequencer #(.RESET_PC(RPC), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .redirect_offset(redirect_offset),
      .pc_out(pc_out), .misalign_fault(misalign_fault), .timeout_fault(timeout_fault)
   );

   // Inputs applied during a cycle and the outputs expected during that same cycle.
   typedef struct {
      logic        rdy;
      logic [31:0] rdata;
      logic        ird;
      logic        ren;
      logic [31:0] rpc;
      logic [31:0] roff;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_ipc;
      logic [31:0] e_pc;
      logic        e_mf;
      logic        e_tf;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic addv(input logic rdy, input logic [31:0] rdata, input logic ird,
                       input logic ren, input logic [31:0] rpc, input logic [31:0] roff,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_ipc,
                       input logic [31:0] e_pc, input logic e_mf, input logic e_tf);
      vec_t v;
      v.rdy = rdy; v.rdata = rdata; v.ird = ird; v.ren = ren; v.rpc = rpc; v.roff = roff;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
      v.e_ipc = e_ipc; v.e_pc = e_pc; v.e_mf = e_mf; v.e_tf = e_tf;
      vq.push_back(v);
   endtask

   task automatic drive(input logic rdy, input logic [31:0] rdata, input logic ird,
                        input logic ren, input logic [31:0] rpc, input logic [31:0] roff);
      imem_ready = rdy; imem_rdata = rdata; instr_ready = ird;
      redirect_en = ren; redirect_pc = rpc; redirect_offset = roff;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      //   rdy rdata          ird ren rpc            roff           req addr          vld instr          ipc            pc             mf tf
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h100,      0, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h100,      0, 32'h0,        32'h0,        32'h100,      0, 0);
      addv(1, 32'h00500093, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h100,      0, 0);
      for (int i = 0; i < 5; i++)
         addv(0, 32'h0,     0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h00500093, 32'h100,      32'h104,      0, 0);
      addv(0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h00500093, 32'h100,      32'h104,      0, 0);
      addv(0, 32'h0,        1, 0, 32'h0,        32'h0,        1, 32'h104,      0, 32'h00500093, 32'h100,      32'h104,      0, 0);
      addv(1, 32'h00A00113, 1, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h00500093, 32'h100,      32'h104,      0, 0);
      addv(0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h00A00113, 32'h104,      32'h108,      0, 0);
      addv(0, 32'h0,        1, 0, 32'h0,        32'h0,        1, 32'h108,      0, 32'h00A00113, 32'h104,      32'h108,      0, 0);
      addv(1, 32'h00000013, 1, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h00A00113, 32'h104,      32'h108,      0, 0);
      addv(0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h00000013, 32'h108,      32'h10C,      0, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h10C,      0, 32'h00000013, 32'h108,      32'h10C,      0, 0);
      // redirect to 0xFC while the fetch of 0x10C is in flight
      addv(0, 32'h0,        0, 1, 32'h104,      32'hFFFFFFF8, 0, 32'h0,        0, 32'h00000013, 32'h108,      32'h10C,      0, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h00000013, 32'h108,      32'hFC,       0, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h00000013, 32'h108,      32'hFC,       0, 0);
      addv(1, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h00000013, 32'h108,      32'hFC,       0, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'hFC,       0, 32'h00000013, 32'h108,      32'hFC,       0, 0);
      addv(1, 32'h11111111, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h00000013, 32'h108,      32'hFC,       0, 0);
      // redirect together with handshake in HOLD, then redirect during REQ
      addv(0, 32'h0,        1, 1, 32'h200,      32'h10,       0, 32'h0,        1, 32'h11111111, 32'hFC,       32'h100,      0, 0);
      addv(0, 32'h0,        0, 1, 32'h300,      32'h0,        1, 32'h210,      0, 32'h11111111, 32'hFC,       32'h210,      0, 0);
      addv(1, 32'h22222222, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h11111111, 32'hFC,       32'h300,      0, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h300,      0, 32'h11111111, 32'hFC,       32'h300,      0, 0);
      // redirect in the same cycle as the response
      addv(1, 32'h33333333, 0, 1, 32'h400,      32'h4,        0, 32'h0,        0, 32'h11111111, 32'hFC,       32'h300,      0, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h404,      0, 32'h11111111, 32'hFC,       32'h404,      0, 0);
      addv(1, 32'h44444444, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h11111111, 32'hFC,       32'h404,      0, 0);
      // redirect in HOLD drops the unaccepted instruction
      addv(0, 32'h0,        0, 1, 32'h500,      32'hFFFFFF00, 0, 32'h0,        1, 32'h44444444, 32'h404,      32'h408,      0, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h400,      0, 32'h44444444, 32'h404,      32'h400,      0, 0);
      addv(1, 32'h55555555, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h44444444, 32'h404,      32'h400,      0, 0);
      // PC wraps past 0xFFFFFFFC
      addv(0, 32'h0,        0, 1, 32'hFFFFFFF0, 32'hC,        0, 32'h0,        1, 32'h55555555, 32'h400,      32'h404,      0, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'hFFFFFFFC, 0, 32'h55555555, 32'h400,      32'hFFFFFFFC, 0, 0);
      addv(1, 32'h66666666, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h55555555, 32'h400,      32'hFFFFFFFC, 0, 0);
      // misaligned redirect, then FAULT ignores redirects and responses
      addv(0, 32'h0,        0, 1, 32'h100,      32'h6,        0, 32'h0,        1, 32'h66666666, 32'hFFFFFFFC, 32'h0,        0, 0);
      addv(1, 32'h77777777, 1, 1, 32'h0,        32'h20,       0, 32'h0,        0, 32'h66666666, 32'hFFFFFFFC, 32'h0,        1, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h66666666, 32'hFFFFFFFC, 32'h0,        1, 0);
      addv(0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h66666666, 32'hFFFFFFFC, 32'h0,        1, 0);

      do_reset();
      for (int i = 0; i < vq.size(); i++) begin
         chk("imem_req",       i, 32'(imem_req),       32'(vq[i].e_req));
         chk("imem_addr",      i, imem_addr,           vq[i].e_addr);
         chk("instr_valid",    i, 32'(instr_valid),    32'(vq[i].e_valid));
         chk("instr",          i, instr,               vq[i].e_instr);
         chk("instr_pc",       i, instr_pc,            vq[i].e_ipc);
         chk("pc_out",         i, pc_out,              vq[i].e_pc);
         chk("misalign_fault", i, 32'(misalign_fault), 32'(vq[i].e_mf));
         chk("timeout_fault",  i, 32'(timeout_fault),  32'(vq[i].e_tf));
         drive(vq[i].rdy, vq[i].rdata, vq[i].ird, vq[i].ren, vq[i].rpc, vq[i].roff);
         @(negedge clk);
      end

      // reset clears the sticky fault; a misaligned redirect faults straight from IDLE
      do_reset();
      chk("rst_mf_clear", 100, 32'(misalign_fault), 32'h0);
      chk("rst_pc",       100, pc_out,              RPC);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h1);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("idle_mf",  101, 32'(misalign_fault), 32'h1);
      chk("idle_req", 101, 32'(imem_req),       32'h0);
      @(negedge clk);
      chk("idle_req2", 102, 32'(imem_req), 32'h0);

      // reset in WAIT overrides a simultaneous response
      do_reset();
      @(negedge clk);
      chk("rw_req", 110, 32'(imem_req), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 32'hABCD0000, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("rw_valid", 111, 32'(instr_valid), 32'h0);
      chk("rw_instr", 111, instr,            32'h0);
      chk("rw_pc",    111, pc_out,           RPC);
      @(negedge clk);
      chk("rw_req2",  112, 32'(imem_req), 32'h1);
      chk("rw_addr2", 112, imem_addr,     RPC);

      // timeout after 16 WAIT cycles with no response; late response ignored
      @(negedge clk);
      chk("to_early", 120, 32'(timeout_fault), 32'h0);
      n = 0;
      while (timeout_fault !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("to_cycles", 121, 32'(n), 32'd16);
      drive(1'b1, 32'h88888888, 1'b1, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_valid", 122 + i, 32'(instr_valid),   32'h0);
         chk("late_req",   122 + i, 32'(imem_req),      32'h0);
         chk("late_instr", 122 + i, instr,              32'h0);
         chk("late_tf",    122 + i, 32'(timeout_fault), 32'h1);
      end

      // misaligned redirect in the timeout cycle sets both faults
      do_reset();
      @(negedge clk);
      @(negedge clk);
      repeat (15) @(negedge clk);
      chk("tm_pre_tf", 130, 32'(timeout_fault), 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h2);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("tm_tf", 131, 32'(timeout_fault),  32'h1);
      chk("tm_mf", 131, 32'(misalign_fault), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
